// File: rtl/rom_reader_pkg.sv
// Shared types and constants for the ROM burst reader.
package rom_reader_pkg;

  localparam int DATA_W     = 24;
  localparam int FIFO_DEPTH = 3;
  localparam int CNT_W      = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_e;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  function automatic logic [CNT_W-1:0] ptr_inc(
    input logic [CNT_W-1:0] p
  );
    return (p == CNT_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/rom_reader_fifo.sv
// Three-entry output buffer holding ROM words plus last flag.
import rom_reader_pkg::*;

module rom_reader_fifo (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  entry_t           i_din,
  input  logic             i_pop,
  output entry_t           o_dout,
  output logic [CNT_W-1:0] o_count
);

  entry_t           mem_q [FIFO_DEPTH];
  logic [CNT_W-1:0] wr_q;
  logic [CNT_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pop_ok;

  assign pop_ok  = i_pop && (cnt_q != '0);
  assign o_dout  = mem_q[rd_q];
  assign o_count = cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (i_push) begin
        mem_q[wr_q] <= i_din;
        wr_q        <= ptr_inc(wr_q);
      end
      if (pop_ok) begin
        rd_q <= ptr_inc(rd_q);
      end
      cnt_q <= cnt_q + CNT_W'(i_push) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/rom_reader.sv
// Streams a burst of ROM words through a 3-deep buffer with backpressure.
// Optional ROM_READER_CHECKSUM_EN adds a running sum of accepted beats.
import rom_reader_pkg::*;

module rom_reader #(
  parameter int ADDR       = 256,
  parameter int ADDR_LINES = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_LINES-1:0] i_base,
  input  logic [ADDR_LINES:0]   i_len,
  output logic [ADDR_LINES-1:0] o_rom_addr,
  output logic                  o_rom_ren,
  input  logic [DATA_W-1:0]     i_rom_data,
  output logic                  o_valid,
  output logic [DATA_W-1:0]     o_data,
  output logic                  o_last,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_done
`ifdef ROM_READER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]     o_checksum
`endif
);

  state_e                state_q;
  logic [ADDR_LINES-1:0] addr_q;
  logic                  ren_q;
  logic                  pend_q;
  logic [ADDR_LINES:0]   rem_q;
  logic [ADDR_LINES:0]   push_left_q;
  logic                  done_q;

  entry_t                head;
  entry_t                din;
  logic [CNT_W-1:0]      fifo_cnt;
  logic                  pop;
  logic [2:0]            cnt_d;
  logic                  can_issue;
  logic [ADDR_LINES:0]   addr_p1;
  logic [ADDR_LINES-1:0] addr_d;

  assign o_valid    = (fifo_cnt != '0);
  assign o_data     = o_valid ? head.data : '0;
  assign o_last     = o_valid & head.last;
  assign o_busy     = (state_q != S_IDLE);
  assign o_done     = done_q;
  assign o_rom_ren  = ren_q;
  assign o_rom_addr = addr_q;
  assign pop        = o_valid & i_ready;

  // Words in the buffer plus the read whose data lands now bound the next issue.
  assign cnt_d     = 3'(fifo_cnt) + 3'(pend_q) - 3'(pop);
  assign can_issue = (cnt_d + 3'(ren_q)) < 3'(FIFO_DEPTH);

  assign addr_p1 = {1'b0, addr_q} + 1'b1;
  assign addr_d  = (addr_p1 == (ADDR_LINES+1)'(ADDR))
                   ? '0 : addr_p1[ADDR_LINES-1:0];

  assign din.last = (push_left_q == (ADDR_LINES+1)'(1));
  assign din.data = i_rom_data;

  rom_reader_fifo u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (pend_q),
    .i_din   (din),
    .i_pop   (pop),
    .o_dout  (head),
    .o_count (fifo_cnt)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      ren_q       <= 1'b0;
      pend_q      <= 1'b0;
      rem_q       <= '0;
      push_left_q <= '0;
      done_q      <= 1'b0;
    end else begin
      pend_q <= ren_q;
      done_q <= 1'b0;
      if (pend_q) begin
        push_left_q <= push_left_q - 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            if (i_len == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q     <= S_READ;
              ren_q       <= 1'b1;
              addr_q      <= i_base;
              rem_q       <= i_len - 1'b1;
              push_left_q <= i_len;
            end
          end
        end
        S_READ: begin
          if (rem_q != '0 && can_issue) begin
            ren_q  <= 1'b1;
            addr_q <= addr_d;
            rem_q  <= rem_q - 1'b1;
          end else begin
            ren_q <= 1'b0;
            if (rem_q == '0) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (pop && o_last) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef ROM_READER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  assign o_checksum = sum_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sum_q <= '0;
    end else if (state_q == S_IDLE && i_start) begin
      sum_q <= '0;
    end else if (pop) begin
      sum_q <= sum_q + o_data;
    end
  end
`endif

endmodule

// File: tb/tb_rom_reader.sv
// Directed bench for rom_reader: timing, wrap, backpressure, reset.
module tb_rom_reader;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [7:0]  i_base = '0;
  logic [8:0]  i_len = '0;
  logic [7:0]  o_rom_addr;
  logic        o_rom_ren;
  logic [23:0] rom_data = '0;
  logic        o_valid;
  logic [23:0] o_data;
  logic        o_last;
  logic        i_ready = 1'b1;
  logic        o_busy;
  logic        o_done;
`ifdef ROM_READER_CHECKSUM_EN
  logic [23:0] o_checksum;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0]  addr_log[$];
  int          ren_cyc[$];
  logic [23:0] beat_data[$];
  logic        beat_last[$];
  int          beat_cyc[$];
  int          done_cyc[$];
  int          rens_tot = 0;
  int          pops_tot = 0;
  int          max_out = 0;
  int          stab_err = 0;
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic        pl = 1'b0;
  logic [23:0] pd = '0;

  rom_reader dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_base     (i_base),
    .i_len      (i_len),
    .o_rom_addr (o_rom_addr),
    .o_rom_ren  (o_rom_ren),
    .i_rom_data (rom_data),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_last     (o_last),
    .i_ready    (i_ready),
    .o_busy     (o_busy),
`ifdef ROM_READER_CHECKSUM_EN
    .o_checksum (o_checksum),
`endif
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] rom_word(input logic [7:0] a);
    if (a == 8'd200) return 24'h800000;
    if (a == 8'd201) return 24'h800001;
    return {4'hA, a[3:0], a, a ^ 8'h5A};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rom_data <= o_rom_ren ? rom_word(o_rom_addr) : 24'h0;
  end

  always @(negedge clk) begin
    int cur;
    if (i_rst) begin
      rens_tot = 0;
      pops_tot = 0;
      pv = 1'b0;
    end else begin
      cur = rens_tot + (o_rom_ren ? 1 : 0) - pops_tot;
      if (cur > max_out) max_out = cur;
      if (pv && !pr && !(o_valid && o_data === pd && o_last === pl))
        stab_err++;
      if (o_rom_ren) begin
        addr_log.push_back(o_rom_addr);
        ren_cyc.push_back(cyc);
        rens_tot++;
      end
      if (o_valid && i_ready) begin
        beat_data.push_back(o_data);
        beat_last.push_back(o_last);
        beat_cyc.push_back(cyc);
        pops_tot++;
      end
      if (o_done) done_cyc.push_back(cyc);
      pv = o_valid;
      pr = i_ready;
      pd = o_data;
      pl = o_last;
    end
  end

  task automatic start(input logic [7:0] b, input int n, output int st);
    @(posedge clk);
    #1;
    i_start = 1'b1;
    i_base = b;
    i_len = 9'(n);
    st = cyc;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string nm);
    checks++;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      #1;
      if (o_done) return;
    end
    errors++;
    $display("FAIL %s: o_done not seen within %0d cycles", nm, bound);
  endtask

  task automatic check_burst(input string nm, input logic [7:0] b,
                             input int n, input int r0, input int b0);
    logic [7:0] a;
    checks++;
    if (addr_log.size() - r0 != n || beat_data.size() - b0 != n) begin
      errors++;
      $display("FAIL %s count: reads %0d beats %0d want %0d", nm,
               addr_log.size() - r0, beat_data.size() - b0, n);
      return;
    end
    for (int i = 0; i < n; i++) begin
      a = 8'(int'(b) + i);
      checks++;
      if (addr_log[r0+i] !== a) begin
        errors++;
        $display("FAIL %s addr[%0d]: got %0d want %0d", nm, i,
                 addr_log[r0+i], a);
      end
      checks++;
      if (beat_data[b0+i] !== rom_word(a) ||
          beat_last[b0+i] !== (i == n - 1)) begin
        errors++;
        $display("FAIL %s beat[%0d]: got %h/%b want %h/%b", nm, i,
                 beat_data[b0+i], beat_last[b0+i], rom_word(a), i == n - 1);
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({o_rom_ren, o_valid, o_last, o_busy, o_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000",
               {o_rom_ren, o_valid, o_last, o_busy, o_done});
    end
    checks++;
    if (o_rom_addr !== 8'd0 || o_data !== 24'd0) begin
      errors++;
      $display("FAIL reset_bus: addr %0d data %h want 0", o_rom_addr, o_data);
    end
    i_rst = 1'b0;
  endtask

  task automatic test_basic;
    int st, r0, b0, d0;
    r0 = addr_log.size();
    b0 = beat_data.size();
    d0 = done_cyc.size();
    i_ready = 1'b1;
    start(8'd10, 4, st);
    wait_done(30, "basic_done");
    @(negedge clk);
    #1;
    check_burst("basic", 8'd10, 4, r0, b0);
    for (int i = 0; i < 4 && r0 + i < ren_cyc.size(); i++) begin
      checks++;
      if (ren_cyc[r0+i] != st + 1 + i) begin
        errors++;
        $display("FAIL basic_ren_cyc[%0d]: got %0d want %0d", i,
                 ren_cyc[r0+i] - st, 1 + i);
      end
    end
    for (int i = 0; i < 4 && b0 + i < beat_cyc.size(); i++) begin
      checks++;
      if (beat_cyc[b0+i] != st + 3 + i) begin
        errors++;
        $display("FAIL basic_beat_cyc[%0d]: got %0d want %0d", i,
                 beat_cyc[b0+i] - st, 3 + i);
      end
    end
    checks++;
    if (done_cyc.size() != d0 + 1 || done_cyc[done_cyc.size()-1] != st + 7) begin
      errors++;
      $display("FAIL basic_done_cyc: got %0d want %0d",
               done_cyc[done_cyc.size()-1] - st, 7);
    end
    checks++;
    if (o_rom_addr !== 8'd13 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: addr %0d busy %b want 13 0",
               o_rom_addr, o_busy);
    end
  endtask

  task automatic test_wrap;
    int st, r0, b0;
    r0 = addr_log.size();
    b0 = beat_data.size();
    start(8'd254, 4, st);
    wait_done(30, "wrap_done");
    @(negedge clk);
    check_burst("wrap", 8'd254, 4, r0, b0);
  endtask

  task automatic test_backpressure;
    int st, r0, b0, d0, k;
    r0 = addr_log.size();
    b0 = beat_data.size();
    d0 = done_cyc.size();
    stab_err = 0;
    max_out = 0;
    start(8'd100, 8, st);
    for (k = 0; k < 120; k++) begin
      @(posedge clk);
      #1;
      if (o_done) break;
      i_ready = (k % 4 == 0) || (k % 4 == 3);
    end
    i_ready = 1'b1;
    checks++;
    if (k == 120) begin
      errors++;
      $display("FAIL bp_timeout: no o_done after %0d cycles", k);
    end
    @(negedge clk);
    #1;
    check_burst("bp", 8'd100, 8, r0, b0);
    checks++;
    if (max_out > 3) begin
      errors++;
      $display("FAIL bp_outstanding: got %0d want <=3", max_out);
    end
    checks++;
    if (stab_err != 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d unstable stalls want 0", stab_err);
    end
    checks++;
    if (done_cyc.size() != d0 + 1) begin
      errors++;
      $display("FAIL bp_done_count: got %0d want 1", done_cyc.size() - d0);
    end
  endtask

  task automatic test_len0_busy;
    int st, st2, dummy, r0, b0, d0;
    r0 = addr_log.size();
    d0 = done_cyc.size();
    start(8'd5, 0, st);
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (addr_log.size() != r0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_reads: got %0d reads busy %b want 0 0",
               addr_log.size() - r0, o_busy);
    end
    checks++;
    if (done_cyc.size() != d0 + 1 || done_cyc[done_cyc.size()-1] != st + 1) begin
      errors++;
      $display("FAIL len0_done: got %0d pulses want 1 at +1",
               done_cyc.size() - d0);
    end
    r0 = addr_log.size();
    b0 = beat_data.size();
    d0 = done_cyc.size();
    start(8'd20, 3, st2);
    start(8'd99, 5, dummy);
    wait_done(30, "busy_done");
    repeat (6) @(negedge clk);
    #1;
    check_burst("busy", 8'd20, 3, r0, b0);
    checks++;
    if (done_cyc.size() != d0 + 1 || done_cyc[done_cyc.size()-1] != st2 + 6) begin
      errors++;
      $display("FAIL busy_done_cyc: got %0d pulses want 1 at +6",
               done_cyc.size() - d0);
    end
  endtask

  task automatic test_reset_mid;
    int st, r0, b0, d0, k;
    r0 = addr_log.size();
    b0 = beat_data.size();
    start(8'd40, 6, st);
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (beat_data.size() >= b0 + 2) break;
    end
    @(posedge clk);
    #1;
    i_rst = 1'b1;
    #1;
    checks++;
    if ({o_rom_ren, o_valid, o_last, o_busy, o_done} !== 5'b0 ||
        o_data !== 24'd0 || o_rom_addr !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset_outs: flags %b data %h addr %0d want 0",
               {o_rom_ren, o_valid, o_last, o_busy, o_done}, o_data,
               o_rom_addr);
    end
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    r0 = addr_log.size();
    b0 = beat_data.size();
    d0 = done_cyc.size();
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (addr_log.size() != r0 || beat_data.size() != b0 ||
        done_cyc.size() != d0) begin
      errors++;
      $display("FAIL mid_reset_quiet: reads %0d beats %0d done %0d want 0",
               addr_log.size() - r0, beat_data.size() - b0,
               done_cyc.size() - d0);
    end
    start(8'd60, 2, st);
    wait_done(30, "restart_done");
    @(negedge clk);
    check_burst("restart", 8'd60, 2, r0, b0);
  endtask

`ifdef ROM_READER_CHECKSUM_EN
  task automatic test_checksum;
    int st;
    start(8'd200, 2, st);
    wait_done(30, "csum_done");
    checks++;
    if (o_checksum !== 24'h000001) begin
      errors++;
      $display("FAIL checksum: got %h want 000001", o_checksum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len0_busy();
    test_reset_mid();
`ifdef ROM_READER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_reader.md
ROM_READER -- requirements
Module: rom_reader

Interface
REQ-001 Parameter ADDR, default 256, ROM depth in words.
REQ-002 Parameter ADDR_LINES, default 8, ROM address width; ADDR SHALL be at most 2**ADDR_LINES.
REQ-003 i_clk  in  1  single clock; all state changes on rising edge.
REQ-004 i_rst  in  1  reset; asynchronous, active-high.
REQ-005 i_start  in  1  one-cycle pulse; begins a burst when idle.
REQ-006 i_base  in  ADDR_LINES  first ROM address of the burst.
REQ-007 i_len  in  ADDR_LINES+1  number of words to read, 0..ADDR.
REQ-008 o_rom_addr  out  ADDR_LINES  ROM address; connects to ROM i_addr.
REQ-009 o_rom_ren  out  1  ROM read enable; connects to ROM i_ren.
REQ-010 i_rom_data  in  24  ROM o_data; valid exactly one cycle after the o_rom_ren cycle.
REQ-011 o_valid / o_data[23:0] / o_last  out  stream beat, data word, final-beat flag.
REQ-012 i_ready  in  1  sink accepts beat when o_valid and i_ready are both high.
REQ-013 o_busy  out  1  high from accepted start until last beat accepted.
REQ-014 o_done  out  1  one-cycle pulse after the last beat is accepted.

Function
REQ-015 FSM states IDLE, READ, DRAIN; IDLE->READ on i_start with i_len>0; READ->DRAIN after i_len reads issued; DRAIN->IDLE when the last beat is accepted.
REQ-016 i_start with i_len=0 SHALL issue no read and pulse o_done the next cycle.
REQ-017 i_start while o_busy is high SHALL be ignored; i_base/i_len are sampled only at accepted start.
REQ-018 The first o_rom_ren SHALL occur the cycle after accepted i_start, with o_rom_addr=i_base.
REQ-019 Successive reads SHALL increment the address by 1, wrapping ADDR-1 -> 0.
REQ-020 Returned ROM words SHALL enter a 3-entry output FIFO the cycle after their o_rom_ren cycle.
REQ-021 o_rom_ren SHALL assert only when FIFO occupancy plus in-flight reads is below 3; no word is ever dropped.
REQ-022 With i_ready held high, throughput SHALL be one beat per cycle; the first o_valid SHALL occur 3 cycles after i_start.
REQ-023 o_data/o_valid/o_last SHALL hold stable while o_valid is high and i_ready is low.
REQ-024 o_last SHALL be high only on beat number i_len of the burst.
REQ-025 o_rom_addr SHALL hold its last value when o_rom_ren is low.

Reset
REQ-026 On i_rst: FSM=IDLE, FIFO emptied, in-flight reads discarded, o_rom_ren=0, o_rom_addr=0, o_valid=0, o_last=0, o_data=0, o_busy=0, o_done=0.
REQ-027 Reset mid-burst SHALL abort the burst without an o_done pulse; ROM data returning after reset release SHALL be ignored.

Configuration
REQ-028 Macro ROM_READER_CHECKSUM_EN defined: output o_checksum[23:0] carries the modulo-2**24 sum of all beats accepted in the current/last burst, cleared at accepted start, valid when o_done pulses.
REQ-029 Macro undefined: o_checksum port and adder SHALL be absent; all other behaviour identical.

Structure
REQ-030 Package rom_reader_pkg SHALL hold DATA_W=24, FIFO_DEPTH=3 and the FSM state typedef.
REQ-031 The output buffer SHALL be sub-module rom_reader_fifo (3 entries, 24+1 bits wide, count output).

Verification
REQ-032 base=10, len=4, ready=1 -> ren at addr 10,11,12,13 on consecutive cycles; 4 beats on consecutive cycles; o_last on beat 4; o_done one cycle after.
REQ-033 base=254, len=4, ADDR=256 -> addresses 254,255,0,1 in order.
REQ-034 len=8, ready toggled 1-0-0-1 repeating -> all 8 words in order, no loss or duplicate, never more than 3 outstanding words (FIFO count + in-flight).
REQ-035 len=0 -> no o_rom_ren, o_done pulse next cycle; i_start while busy -> ignored, burst unchanged.
REQ-036 i_rst asserted after 2 of 6 beats -> all outputs 0 immediately; no o_done; new burst after release starts cleanly at new base.
REQ-037 With ROM_READER_CHECKSUM_EN, ROM words 0x800000,0x800001 -> o_checksum=0x000001 at o_done.
